dmem_ctrl: RTL and testbench
============================

# dmem_ctrl

Parametrised, multi-cycle data memory for the RV32I core's load/store path. Accepts one byte-addressed request at a time over a valid/ready handshake. Supports the RV32I load/store widths LB/LH/LW/LBU/LHU/SB/SH/SW with little-endian byte lanes, sign/zero extension, and a configurable number of wait states. Misaligned, out-of-range and illegal-width accesses return an error response and never modify memory.

## Interface
Parameters:
- ADDR_W, 32, request address width in bits; byte address.
- DEPTH_WORDS, 4096, number of 32-bit words in the array.
- LATENCY, 1, wait-state cycles inserted before the response; legal range 0..15.

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request; equals (state==IDLE) && !rst.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32I width code: 0 B, 1 H, 2 W, 4 BU, 5 HU.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data; the low byte/half/word is used according to the width.
- rsp_valid  out  1  response present; held until it is accepted.
- rsp_ready  in  1  consumer accepts the response.
- rsp_rdata  out  32  extended load data; 0 for stores and errors.
- rsp_err  out  1  access rejected.

## Operation
- FSM states: IDLE, WAIT, RESP.
  - IDLE: on req_valid && req_ready, capture we, funct3, addr and wdata.
    - If the request is an error, go to RESP.
    - Else if LATENCY==0, go to RESP.
    - Else go to WAIT with cnt = LATENCY-1.
  - WAIT: decrement cnt; when cnt==0, go to RESP.
  - RESP: hold rsp_valid=1; on rsp_ready, return to IDLE.
- The memory access is performed on the edge that enters RESP from a non-error path.
  - Store: write the selected byte lanes only.
  - Load: latch the word and extend it into rsp_rdata.
- Word index = addr[ADDR_W-1:2]; byte offset = addr[1:0]; lane k holds bits 8k+7:8k.
- Store lane enables:
  - SB: lane offset.
  - SH: lanes offset and offset+1.
  - SW: all four lanes.
- Load extraction:
  - LB/LBU: byte at offset, sign/zero-extended.
  - LH/LHU: bytes offset+1:offset, sign/zero-extended.
  - LW: whole word.
- Error conditions; any one sets rsp_err=1 with no array write and rsp_rdata=0:
  - Halfword access with addr[0]=1.
  - Word access with addr[1:0]!=0.
  - Word index >= DEPTH_WORDS.
  - funct3 in {3,6,7}.
  - Store with funct3 in {4,5}.
- The array is not reset. Contents are undefined until written, except that simulation initialises every word to 0.

## Timing
- Reset values: state=IDLE, cnt=0, rsp_valid=0, rsp_rdata=0, rsp_err=0. req_ready=0 while rst=1.
- A request accepted at edge N gives rsp_valid=1 from the cycle after edge N+LATENCY.
  - LATENCY=0: response visible the cycle after acceptance.
  - Error responses always appear the cycle after acceptance, regardless of LATENCY.
- Maximum throughput is one request per LATENCY+2 cycles when rsp_ready is held at 1. A new request cannot be accepted in the same cycle a response is accepted.
- rsp_rdata and rsp_err are stable for the whole time rsp_valid=1.
- Back-pressure: rsp_ready=0 holds RESP indefinitely. Outputs are unchanged and req_ready stays 0.
- Reset mid-operation:
  - rst in WAIT discards the request; no write occurs.
  - rst on the edge that would enter RESP takes priority, so no write occurs.
  - rst in RESP drops the response.
- Inputs are sampled only at acceptance; changes to req_* afterwards have no effect.

## Test plan
- LATENCY=2: SW addr 0x100 data 0xDEADBEEF, then LW 0x100. Each rsp_valid rises exactly 3 cycles after acceptance; load returns 0xDEADBEEF with err=0.
- After word 0x100=0xDEADBEEF: SB 0x101 data 0x55, then LB/LBU 0x101 → 0x00000055; LH 0x102 → 0xFFFFDEAD; LHU 0x102 → 0x0000DEAD; LW 0x100 → 0xDEAD55EF.
- LH 0x103, SW 0x102, and LW at byte address 4*DEPTH_WORDS each give err=1, rdata=0 one cycle after acceptance. A following LW of the affected words shows they are unchanged.
- SB with funct3=4, and a load with funct3=7 → err=1 and no write.
- LATENCY=0, rsp_ready held 0 for 5 cycles: rsp_valid and data held and req_ready=0 throughout; rsp_ready=1 returns to IDLE and req_ready=1 the next cycle.
- SW 0x200 data 0x12345678 with rst pulsed during WAIT (LATENCY=3): no response. A subsequent LW 0x200 returns the prior contents (0 in simulation).

Source files
------------

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: multi-cycle byte-addressed data memory for the RV32I load/store path.
// Ports: clk/rst (sync, active-high); req_* valid/ready request (we, funct3 width code,
//        byte addr, store data); rsp_* valid/ready response (extended load data, error flag).
// Latency: LATENCY wait states before the response (errors respond the cycle after accept).
module dmem_ctrl #(
  parameter int ADDR_W      = 32,
  parameter int DEPTH_WORDS = 4096,
  parameter int LATENCY     = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err
);

  localparam int         IDX_W  = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0] LAT_M1 = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t state, state_nxt;
  logic [3:0] cnt, cnt_nxt;

  // Request captured at acceptance; only the address bits that reach the array are kept.
  logic             we_q;
  logic [2:0]       f3_q;
  logic [IDX_W+1:0] addr_q;
  logic [31:0]      wdata_q;

  logic             accept, req_err, do_access, mem_we;
  logic             acc_we;
  logic [2:0]       acc_f3;
  logic [IDX_W+1:0] acc_addr;
  logic [31:0]      acc_wdata;
  logic [IDX_W-1:0] idx;
  logic [1:0]       off;
  logic [3:0]       be;
  logic [31:0]      wd_sh, rd_word, rd_sh, ld_data;

  logic [31:0] mem [DEPTH_WORDS];

  assign req_ready = (state == IDLE) && !rst;
  assign rsp_valid = (state == RESP);
  assign accept    = req_valid && req_ready;

  always_comb begin
    req_err = 1'b0;
    case (req_funct3)
      3'd0, 3'd4: req_err = 1'b0;
      3'd1, 3'd5: req_err = req_addr[0];
      3'd2:       req_err = (req_addr[1:0] != 2'b00);
      default:    req_err = 1'b1;
    endcase
    if (req_we && (req_funct3 == 3'd4 || req_funct3 == 3'd5)) req_err = 1'b1;
    if ({2'b00, req_addr[ADDR_W-1:2]} >= ADDR_W'(DEPTH_WORDS)) req_err = 1'b1;
  end

  // With LATENCY==0 the access happens on the accepting edge, before the capture
  // registers hold the request, so the live inputs feed the datapath while in IDLE.
  always_comb begin
    if (state == IDLE) begin
      acc_we    = req_we;
      acc_f3    = req_funct3;
      acc_addr  = req_addr[IDX_W+1:0];
      acc_wdata = req_wdata;
    end else begin
      acc_we    = we_q;
      acc_f3    = f3_q;
      acc_addr  = addr_q;
      acc_wdata = wdata_q;
    end
  end

  assign idx   = acc_addr[IDX_W+1:2];
  assign off   = acc_addr[1:0];
  assign wd_sh = acc_wdata << {off, 3'b000};
  assign rd_word = mem[idx];
  assign rd_sh = rd_word >> {off, 3'b000};

  always_comb begin
    case (acc_f3[1:0])
      2'd0:    be = 4'b0001 << off;
      2'd1:    be = 4'b0011 << off;
      default: be = 4'b1111;
    endcase
  end

  // Word loads are always aligned, so rd_sh equals rd_word for them.
  always_comb begin
    case (acc_f3)
      3'd0:    ld_data = {{24{rd_sh[7]}}, rd_sh[7:0]};
      3'd1:    ld_data = {{16{rd_sh[15]}}, rd_sh[15:0]};
      3'd4:    ld_data = {24'd0, rd_sh[7:0]};
      3'd5:    ld_data = {16'd0, rd_sh[15:0]};
      default: ld_data = rd_sh;
    endcase
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    do_access = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (req_err) begin
            state_nxt = RESP;
          end else if (LATENCY == 0) begin
            state_nxt = RESP;
            do_access = 1'b1;
          end else begin
            state_nxt = WAIT;
            cnt_nxt   = LAT_M1;
          end
        end
      end
      WAIT: begin
        if (cnt == 4'd0) begin
          state_nxt = RESP;
          do_access = 1'b1;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      RESP: begin
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Reset wins over the edge that would perform the access.
  assign mem_we = do_access && acc_we && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
      we_q      <= 1'b0;
      f3_q      <= 3'd0;
      addr_q    <= '0;
      wdata_q   <= 32'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) begin
        we_q      <= req_we;
        f3_q      <= req_funct3;
        addr_q    <= req_addr[IDX_W+1:0];
        wdata_q   <= req_wdata;
        rsp_err   <= req_err;
        rsp_rdata <= 32'd0;
      end
      if (do_access) begin
        rsp_err   <= 1'b0;
        rsp_rdata <= acc_we ? 32'd0 : ld_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int k = 0; k < 4; k++) begin
        if (be[k]) mem[idx][8*k +: 8] <= wd_sh[8*k +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// tb_dmem_ctrl: bench for dmem_ctrl with three instances (LATENCY 2, 0, 3) sharing
// request buses; each instance has its own req_valid/rsp_ready. Expected responses are
// queued when a request is driven and popped when the response appears.
module tb_dmem_ctrl;

  localparam int DEPTH = 256;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  vld_v;
  logic [2:0]  rrdy_v;
  logic        we;
  logic [2:0]  f3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [2:0]  rdy_o;
  logic [2:0]  vld_o;
  logic [2:0]  err_o;
  logic [31:0] rdata_o [3];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int LAT = (g == 0) ? 2 : ((g == 1) ? 0 : 3);
    dmem_ctrl #(.ADDR_W(32), .DEPTH_WORDS(DEPTH), .LATENCY(LAT)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (vld_v[g]),
      .req_ready (rdy_o[g]),
      .req_we    (we),
      .req_funct3(f3),
      .req_addr  (addr),
      .req_wdata (wdata),
      .rsp_valid (vld_o[g]),
      .rsp_ready (rrdy_v[g]),
      .rsp_rdata (rdata_o[g]),
      .rsp_err   (err_o[g])
    );
  end

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    string       name;
  } exp_t;
  exp_t sbq[$];

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
  } vec_t;

  function automatic int lat_of(input int s);
    return (s == 0) ? 2 : ((s == 1) ? 0 : 3);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  // Drives a request on instance s and returns at the falling edge after acceptance.
  task automatic accept_req(input int s, input logic w, input logic [2:0] fn,
                            input logic [31:0] a, input logic [31:0] d);
    int n;
    @(negedge clk);
    we = w; f3 = fn; addr = a; wdata = d;
    vld_v = 3'b000;
    vld_v[s] = 1'b1;
    n = 0;
    while (!rdy_o[s] && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!rdy_o[s]) chk("accept_timeout", 32'(rdy_o[s]), 32'd1);
    @(posedge clk);
    @(negedge clk);
    vld_v = 3'b000;
    // Scramble the request bus; the block must use only what it captured.
    we = 1'($urandom); f3 = 3'($urandom); addr = $urandom; wdata = $urandom;
  endtask

  task automatic do_req(input int s, input logic w, input logic [2:0] fn,
                        input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] exp_rd, input logic exp_err, input string name);
    exp_t e;
    int   lat;
    e.rdata = exp_rd;
    e.err   = exp_err;
    e.lat   = exp_err ? 0 : lat_of(s);
    e.name  = name;
    sbq.push_back(e);
    accept_req(s, w, fn, a, d);
    lat = 0;
    while (!vld_o[s] && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    e = sbq.pop_front();
    chk({e.name, "_valid"}, 32'(vld_o[s]), 32'd1);
    chk({e.name, "_lat"}, 32'(lat), 32'(e.lat));
    chk({e.name, "_rdata"}, rdata_o[s], e.rdata);
    chk({e.name, "_err"}, 32'(err_o[s]), 32'(e.err));
    rrdy_v[s] = 1'b1;
    @(negedge clk);
    rrdy_v = 3'b000;
  endtask

  vec_t vt[25];

  initial begin
    exp_t e;
    vt[0]  = '{1'b1, 3'd2, 32'h100, 32'hDEADBEEF, 32'h0,        1'b0};
    vt[1]  = '{1'b0, 3'd2, 32'h100, 32'h0,        32'hDEADBEEF, 1'b0};
    vt[2]  = '{1'b1, 3'd0, 32'h101, 32'hFFFFFF55, 32'h0,        1'b0};
    vt[3]  = '{1'b0, 3'd0, 32'h101, 32'h0,        32'h00000055, 1'b0};
    vt[4]  = '{1'b0, 3'd4, 32'h101, 32'h0,        32'h00000055, 1'b0};
    vt[5]  = '{1'b0, 3'd1, 32'h102, 32'h0,        32'hFFFFDEAD, 1'b0};
    vt[6]  = '{1'b0, 3'd5, 32'h102, 32'h0,        32'h0000DEAD, 1'b0};
    vt[7]  = '{1'b0, 3'd2, 32'h100, 32'h0,        32'hDEAD55EF, 1'b0};
    vt[8]  = '{1'b0, 3'd1, 32'h103, 32'h0,        32'h0,        1'b1};
    vt[9]  = '{1'b1, 3'd2, 32'h102, 32'h11111111, 32'h0,        1'b1};
    vt[10] = '{1'b0, 3'd2, 32'h400, 32'h0,        32'h0,        1'b1};
    vt[11] = '{1'b1, 3'd4, 32'h100, 32'h000000AA, 32'h0,        1'b1};
    vt[12] = '{1'b0, 3'd7, 32'h100, 32'h0,        32'h0,        1'b1};
    vt[13] = '{1'b1, 3'd3, 32'h100, 32'h22222222, 32'h0,        1'b1};
    vt[14] = '{1'b1, 3'd5, 32'h100, 32'h00001234, 32'h0,        1'b1};
    vt[15] = '{1'b0, 3'd6, 32'h100, 32'h0,        32'h0,        1'b1};
    vt[16] = '{1'b0, 3'd2, 32'h100, 32'h0,        32'hDEAD55EF, 1'b0};
    vt[17] = '{1'b1, 3'd1, 32'h106, 32'hFFFF8001, 32'h0,        1'b0};
    vt[18] = '{1'b0, 3'd1, 32'h106, 32'h0,        32'hFFFF8001, 1'b0};
    vt[19] = '{1'b0, 3'd5, 32'h106, 32'h0,        32'h00008001, 1'b0};
    vt[20] = '{1'b0, 3'd0, 32'h103, 32'h0,        32'hFFFFFFDE, 1'b0};
    vt[21] = '{1'b1, 3'd2, 32'h3FC, 32'hA5A5A5A5, 32'h0,        1'b0};
    vt[22] = '{1'b0, 3'd2, 32'h3FC, 32'h0,        32'hA5A5A5A5, 1'b0};
    vt[23] = '{1'b0, 3'd4, 32'h3FF, 32'h0,        32'h000000A5, 1'b0};
    vt[24] = '{1'b0, 3'd2, 32'hFFFFFFFC, 32'h0,   32'h0,        1'b1};

    rst = 1'b1; vld_v = 3'b000; rrdy_v = 3'b000;
    we = 1'b0; f3 = 3'd0; addr = 32'd0; wdata = 32'd0;
    repeat (3) @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      chk($sformatf("rst_ready%0d", s), 32'(rdy_o[s]), 32'd0);
      chk($sformatf("rst_valid%0d", s), 32'(vld_o[s]), 32'd0);
      chk($sformatf("rst_rdata%0d", s), rdata_o[s], 32'd0);
      chk($sformatf("rst_err%0d", s), 32'(err_o[s]), 32'd0);
    end
    rst = 1'b0;
    @(negedge clk);
    for (int s = 0; s < 3; s++) chk($sformatf("post_rst_ready%0d", s), 32'(rdy_o[s]), 32'd1);

    // Table-driven pass on the LATENCY=2 instance.
    for (int i = 0; i < 25; i++)
      do_req(0, vt[i].we, vt[i].f3, vt[i].addr, vt[i].wdata, vt[i].rdata, vt[i].err,
             $sformatf("vec%0d", i));

    // LATENCY=0: response held under back-pressure.
    do_req(1, 1'b1, 3'd2, 32'h10, 32'h0BADF00D, 32'h0, 1'b0, "l0_sw");
    e.rdata = 32'h0BADF00D; e.err = 1'b0; e.lat = 0; e.name = "l0_bp";
    sbq.push_back(e);
    accept_req(1, 1'b0, 3'd2, 32'h10, 32'h0);
    e = sbq.pop_front();
    chk({e.name, "_valid"}, 32'(vld_o[1]), 32'd1);
    for (int c = 0; c < 5; c++) begin
      if (c > 0) @(negedge clk);
      chk($sformatf("%s_hold_valid%0d", e.name, c), 32'(vld_o[1]), 32'd1);
      chk($sformatf("%s_hold_rdata%0d", e.name, c), rdata_o[1], e.rdata);
      chk($sformatf("%s_hold_err%0d", e.name, c), 32'(err_o[1]), 32'(e.err));
      chk($sformatf("%s_hold_ready%0d", e.name, c), 32'(rdy_o[1]), 32'd0);
    end
    rrdy_v[1] = 1'b1;
    @(negedge clk);
    rrdy_v = 3'b000;
    chk("l0_release_ready", 32'(rdy_o[1]), 32'd1);
    chk("l0_release_valid", 32'(vld_o[1]), 32'd0);
    do_req(1, 1'b0, 3'd1, 32'h11, 32'h0, 32'h0, 1'b1, "l0_err");

    // LATENCY=3: reset during WAIT, on the RESP-entering edge, and in RESP.
    do_req(2, 1'b1, 3'd2, 32'h200, 32'hCAFEF00D, 32'h0, 1'b0, "l3_sw");
    do_req(2, 1'b0, 3'd1, 32'h203, 32'h0, 32'h0, 1'b1, "l3_err");
    accept_req(2, 1'b1, 3'd2, 32'h200, 32'h12345678);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      chk($sformatf("wait_rst_no_rsp%0d", c), 32'(vld_o[2]), 32'd0);
      @(negedge clk);
    end
    chk("wait_rst_ready", 32'(rdy_o[2]), 32'd1);
    do_req(2, 1'b0, 3'd2, 32'h200, 32'h0, 32'hCAFEF00D, 1'b0, "wait_rst_lw");

    accept_req(2, 1'b1, 3'd2, 32'h200, 32'h0F0F0F0F);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      chk($sformatf("edge_rst_no_rsp%0d", c), 32'(vld_o[2]), 32'd0);
      @(negedge clk);
    end
    do_req(2, 1'b0, 3'd2, 32'h200, 32'h0, 32'hCAFEF00D, 1'b0, "edge_rst_lw");

    accept_req(2, 1'b0, 3'd2, 32'h200, 32'h0);
    repeat (3) @(negedge clk);
    chk("resp_rst_pre_valid", 32'(vld_o[2]), 32'd1);
    chk("resp_rst_pre_rdata", rdata_o[2], 32'hCAFEF00D);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("resp_rst_valid", 32'(vld_o[2]), 32'd0);
    chk("resp_rst_rdata", rdata_o[2], 32'd0);
    chk("resp_rst_err", 32'(err_o[2]), 32'd0);
    @(negedge clk);
    chk("resp_rst_ready", 32'(rdy_o[2]), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
